dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port 8 KB data memory between the CPU load/store stage (port m0) and the program/data loader (port m1). Each cycle it grants at most one requester, drives the memory's `en/wr/addr/wdata` from that requester, registers read data back to the winning port, and supports short locked bursts with a watchdog. It sits between the two masters and the data memory; the memory's read path is combinational and its write commits on the clock edge.

## Interface
- `LOCK_MAX`, default 16: maximum consecutive cycles a lock may be held before forced release (range 1..255).
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m0_req` / `m1_req` in 1: access request, held until granted.
- `m0_wr` / `m1_wr` in 1: 1 = write, 0 = read.
- `m0_addr` / `m1_addr` in 32: byte address (memory forces word alignment).
- `m0_wdata` / `m1_wdata` in 32: write data, big-endian word.
- `m0_lock` / `m1_lock` in 1: request exclusive ownership after this beat.
- `m0_gnt` / `m1_gnt` out 1: combinational grant, same cycle as accepted request.
- `m0_rvalid` / `m1_rvalid` out 1: one-cycle pulse, read data valid.
- `m0_rdata` / `m1_rdata` out 32: registered read data, held between reads.
- `mem_en`, `mem_wr` out 1; `mem_addr`, `mem_wdata` out 32: to data memory.
- `mem_rdata` in 32: combinational read data from memory.

## Operation
- Grant: at most one of `m0_gnt`/`m1_gnt` high; a granted beat is exactly one cycle. `mem_en = m0_gnt | m1_gnt`; `mem_wr/addr/wdata` muxed from granted port; all zero when no grant.
- Lock state: `lock_own` ∈ {NONE, M0, M1}, plus 8-bit `lock_cnt`.
  - NONE -> Mx when Mx is granted with `mx_lock=1`; `lock_cnt` cleared.
  - Mx -> NONE when Mx is granted with `mx_lock=0`, or when `lock_cnt` reaches `LOCK_MAX` (forced release).
  - While owned by Mx, only Mx can be granted; the other port waits even if Mx is idle. `lock_cnt` increments every cycle in the owned state, saturating.
  - On forced release, the non-owner wins the next conflict regardless of arbitration mode.
- Arbitration when NONE and both request: see Configuration. Single requester is always granted immediately.
- `last_gnt` register records the port granted in the most recent granted cycle.
- Read beat: at the edge ending the grant cycle, `mem_rdata` is captured into the winner's `rdata`, and its `rvalid` pulses for the following cycle. Write beat: no `rvalid`, and `rdata` is unchanged.
- Requester dropping `req` without a grant is legal; nothing is recorded.

## Timing
- Reset values: `m0/m1_rvalid=0`, `m0/m1_rdata=0`, `lock_own=NONE`, `lock_cnt=0`, `last_gnt=M1` (so M0 wins first conflict). `gnt` and `mem_*` are 0 while `req` is low.
- Grant latency 0 cycles (uncontended). Read data latency 1 cycle after grant. Write visible in memory for reads starting the next cycle.
- Back-to-back beats from one port: one per cycle; `rvalid` may be high every cycle.
- Reset mid-lock or mid-read: lock cleared, pending `rvalid` suppressed. A write granted in the same cycle as `rst` assertion is not guaranteed.
- `LOCK_MAX` comparison: release occurs in the cycle where `lock_cnt == LOCK_MAX`; the owner is not granted in that cycle.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On conflict, grant the port that is not `last_gnt`.
- Undefined: fixed priority. M0 always wins conflicts, except after a forced lock release (watchdog rule still applies). `last_gnt` is still maintained.

## Test plan
- Single read: M0 reads 0x10 after M1 writes 0x12345678 there -> `m0_gnt` same cycle, `m0_rvalid` next cycle with `m0_rdata=0x12345678`.
- Conflict: both request reads every cycle for 4 cycles -> with RR, grants M0,M1,M0,M1; without RR, M0 ×4 and M1 starved.
- Lock burst: M1 writes 4 words with `lock=1,1,1,0` while M0 requests -> M0 is not granted until the cycle after the lock=0 beat.
- Watchdog: `LOCK_MAX=4`, M1 locks then idles, M0 requests -> M0 is granted exactly after the forced release, and `lock_own=NONE`.
- Reset: assert `rst` in the cycle after a granted read -> `rvalid=0` and `rdata=0`, `lock_own=NONE`; the first conflict after reset goes to M0.
- Unaligned: M0 reads 0x13 after a write to 0x10 -> returns the word at 0x10.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU load/store port (m0) and the
// loader port (m1). Grants at most one beat per cycle, muxes it onto the memory bus, registers
// read data back to the winner, and supports locked bursts guarded by a watchdog.
//
// Build option: define DMEM_ARB_RR_EN for round-robin conflict arbitration; otherwise m0 has
// fixed priority. In both modes the non-owner wins the first conflict after a forced release.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   mX_req_i / mX_wr_i            request, 1 = write
//   mX_addr_i / mX_wdata_i        byte address, write data
//   mX_lock_i                     keep ownership after this beat
//   mX_gnt_o                      combinational grant
//   mX_rvalid_o / mX_rdata_o      one-cycle read valid pulse, registered read data
//   mem_en_o/mem_wr_o/mem_addr_o/mem_wdata_o   memory request (all zero when idle)
//   mem_rdata_i                   combinational read data from memory
module dmem_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_wr_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_lock_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_wr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_lock_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        mem_en_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [7:0] LockMaxC = 8'(LOCK_MAX);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnM0   = 2'd1,
    OwnM1   = 2'd2
  } lock_own_e;

  lock_own_e   lock_own_q, lock_own_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        last_gnt_q, last_gnt_d;  // 0 = m0, 1 = m1
  logic        wd_pri_q, wd_pri_d;      // watchdog priority pending
  logic        wd_port_q, wd_port_d;    // port favoured by the pending watchdog priority
  logic        m0_rvalid_q, m0_rvalid_d;
  logic        m1_rvalid_q, m1_rvalid_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic gnt0, gnt1;
  logic wd_fire;
  logic conflict_m1;

  // Grant decision.
  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    wd_fire     = 1'b0;
`ifdef DMEM_ARB_RR_EN
    conflict_m1 = ~last_gnt_q;
`else
    conflict_m1 = 1'b0;
`endif
    if (wd_pri_q) begin
      conflict_m1 = wd_port_q;
    end
    unique case (lock_own_q)
      OwnM0: begin
        // The release cycle itself grants nobody; the freed port competes next cycle.
        wd_fire = (lock_cnt_q == LockMaxC);
        gnt0    = m0_req_i & ~wd_fire;
      end
      OwnM1: begin
        wd_fire = (lock_cnt_q == LockMaxC);
        gnt1    = m1_req_i & ~wd_fire;
      end
      default: begin
        if (m0_req_i && m1_req_i) begin
          gnt0 = ~conflict_m1;
          gnt1 = conflict_m1;
        end else begin
          gnt0 = m0_req_i;
          gnt1 = m1_req_i;
        end
      end
    endcase
  end

  // Lock ownership, watchdog and arbitration history.
  always_comb begin
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    wd_pri_d   = wd_pri_q;
    wd_port_d  = wd_port_q;
    last_gnt_d = last_gnt_q;
    unique case (lock_own_q)
      OwnM0: begin
        if (wd_fire) begin
          lock_own_d = OwnNone;
          wd_pri_d   = 1'b1;
          wd_port_d  = 1'b1;
        end else if (gnt0 && !m0_lock_i) begin
          lock_own_d = OwnNone;
        end else if (lock_cnt_q != 8'hff) begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
      OwnM1: begin
        if (wd_fire) begin
          lock_own_d = OwnNone;
          wd_pri_d   = 1'b1;
          wd_port_d  = 1'b0;
        end else if (gnt1 && !m1_lock_i) begin
          lock_own_d = OwnNone;
        end else if (lock_cnt_q != 8'hff) begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
      default: begin
        if (gnt0 && m0_lock_i) begin
          lock_own_d = OwnM0;
          lock_cnt_d = 8'd0;
        end else if (gnt1 && m1_lock_i) begin
          lock_own_d = OwnM1;
          lock_cnt_d = 8'd0;
        end
      end
    endcase
    if (gnt0 || gnt1) begin
      last_gnt_d = gnt1;
      // Priority is spent once the favoured port gets a beat.
      if (wd_pri_q && (gnt1 == wd_port_q)) begin
        wd_pri_d = 1'b0;
      end
    end
  end

  // Read return path.
  always_comb begin
    m0_rvalid_d = gnt0 & ~m0_wr_i;
    m1_rvalid_d = gnt1 & ~m1_wr_i;
    m0_rdata_d  = m0_rvalid_d ? mem_rdata_i : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? mem_rdata_i : m1_rdata_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_own_q  <= OwnNone;
      lock_cnt_q  <= 8'd0;
      last_gnt_q  <= 1'b1;
      wd_pri_q    <= 1'b0;
      wd_port_q   <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= 32'd0;
      m1_rdata_q  <= 32'd0;
    end else begin
      lock_own_q  <= lock_own_d;
      lock_cnt_q  <= lock_cnt_d;
      last_gnt_q  <= last_gnt_d;
      wd_pri_q    <= wd_pri_d;
      wd_port_q   <= wd_port_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;

  assign mem_en_o    = gnt0 | gnt1;
  assign mem_wr_o    = (gnt0 & m0_wr_i) | (gnt1 & m1_wr_i);
  assign mem_addr_o  = ({32{gnt0}} & m0_addr_i) | ({32{gnt1}} & m1_addr_i);
  assign mem_wdata_o = ({32{gnt0}} & m0_wdata_i) | ({32{gnt1}} & m1_wdata_i);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed stimulus with hand-computed literal checks, plus a
// behavioural model checked against every output on every falling edge.
module tb_dmem_arbiter;

  localparam int LockMax = 4;

  logic        clk;
  logic        rst;
  logic        mem_clr;
  logic        m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.LOCK_MAX(LockMax)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m0_req_i    (m0_req),
    .m0_wr_i     (m0_wr),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m0_lock_i   (m0_lock),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_wr_i     (m1_wr),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_lock_i   (m1_lock),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .mem_en_o    (mem_en),
    .mem_wr_o    (mem_wr),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 8 KB word memory: combinational read, write on the clock edge, word aligned.
  logic [31:0] env_mem [2048];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) env_mem[i] <= '0;
    end else if (mem_en && mem_wr) begin
      env_mem[mem_addr[12:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = env_mem[mem_addr[12:2]];

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] shadow [2048];
  logic        own_v, own_p, fav_v, fav_p, last_p, win_v, win_p;
  int          held;
  logic [1:0]  rq, wrv, lkv, m_rv, nrv;
  logic [31:0] ad [2];
  logic [31:0] wdv [2];
  logic [31:0] m_rd [2];
  logic        rr_mode;

  initial begin
`ifdef DMEM_ARB_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    for (int i = 0; i < 2048; i++) shadow[i] = '0;
    own_v = 0; own_p = 0; fav_v = 0; fav_p = 0; last_p = 1; held = 0;
    m_rv = 2'b00; m_rd[0] = '0; m_rd[1] = '0;
    forever begin
      @(negedge clk);
      rq = {m1_req, m0_req};
      wrv = {m1_wr, m0_wr};
      lkv = {m1_lock, m0_lock};
      ad[0] = m0_addr; ad[1] = m1_addr;
      wdv[0] = m0_wdata; wdv[1] = m1_wdata;
      if (rst) begin
        own_v = 0; fav_v = 0; last_p = 1; held = 0;
        m_rv = 2'b00; m_rd[0] = '0; m_rd[1] = '0;
      end
      // Who must win this cycle.
      win_v = 0; win_p = 0;
      if (own_v) begin
        if (held < LockMax && rq[own_p]) begin win_v = 1; win_p = own_p; end
      end else if (rq == 2'b11) begin
        win_v = 1;
        win_p = fav_v ? fav_p : (rr_mode ? ~last_p : 1'b0);
      end else if (rq != 2'b00) begin
        win_v = 1;
        win_p = rq[1];
      end
      check1("m0_gnt", m0_gnt, win_v && !win_p);
      check1("m1_gnt", m1_gnt, win_v && win_p);
      check1("mem_en", mem_en, win_v);
      check1("mem_wr", mem_wr, win_v && wrv[win_p]);
      check32("mem_addr", mem_addr, win_v ? ad[win_p] : 32'd0);
      check32("mem_wdata", mem_wdata, win_v ? wdv[win_p] : 32'd0);
      check1("m0_rvalid", m0_rvalid, m_rv[0]);
      check1("m1_rvalid", m1_rvalid, m_rv[1]);
      check32("m0_rdata", m0_rdata, m_rd[0]);
      check32("m1_rdata", m1_rdata, m_rd[1]);
      if (!rst) begin
        nrv = 2'b00;
        if (win_v) begin
          if (!wrv[win_p]) begin
            nrv[win_p] = 1'b1;
            m_rd[win_p] = shadow[ad[win_p][12:2]];
          end else begin
            shadow[ad[win_p][12:2]] = wdv[win_p];
          end
        end
        m_rv = nrv;
        if (own_v) begin
          if (held == LockMax) begin
            fav_v = 1; fav_p = ~own_p; own_v = 0;
          end else if (win_v && win_p == own_p && !lkv[win_p]) begin
            own_v = 0;
          end else begin
            held++;
          end
        end else if (win_v && lkv[win_p]) begin
          own_v = 1; own_p = win_p; held = 0;
        end
        if (win_v) begin
          last_p = win_p;
          if (fav_v && fav_p == win_p) fav_v = 0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic p, input logic req, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic lk);
    if (!p) begin
      m0_req = req; m0_wr = wr; m0_addr = addr; m0_wdata = wd; m0_lock = lk;
    end else begin
      m1_req = req; m1_wr = wr; m1_addr = addr; m1_wdata = wd; m1_lock = lk;
    end
  endtask

  task automatic idle(input logic p);
    drive(p, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] conf_m0;

  initial begin
`ifdef DMEM_ARB_RR_EN
    conf_m0 = 4'b0101;
`else
    conf_m0 = 4'b1111;
`endif
    rst = 1'b1; mem_clr = 1'b1;
    idle(1'b0); idle(1'b1);
    repeat (3) @(posedge clk);
    #1;
    #2;
    check1("reset_m0_rvalid", m0_rvalid, 1'b0);
    check32("reset_m0_rdata", m0_rdata, 32'd0);
    rst = 1'b0; mem_clr = 1'b0;

    // Writes by m1, then reads by m0 including an unaligned address.
    drive(1'b1, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 1'b0);
    #2; check1("wr10_m1_gnt", m1_gnt, 1'b1);
    step();
    drive(1'b1, 1'b1, 1'b1, 32'h14, 32'hCAFE_F00D, 1'b0);
    step();
    idle(1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
    #2; check1("rd10_m0_gnt", m0_gnt, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h13, 32'd0, 1'b0);
    #2;
    check1("rd10_m0_rvalid", m0_rvalid, 1'b1);
    check32("rd10_m0_rdata", m0_rdata, 32'h1234_5678);
    step();
    idle(1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'h18, 32'h0BAD_BEEF, 1'b0);
    #2;
    check1("rd13_m0_rvalid", m0_rvalid, 1'b1);
    check32("rd13_m0_rdata", m0_rdata, 32'h1234_5678);
    step();

    // Four cycles of read conflict.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 32'h18, 32'd0, 1'b0);
      #2;
      check1("conflict_m0_gnt", m0_gnt, conf_m0[k]);
      check1("conflict_m1_gnt", m1_gnt, ~conf_m0[k]);
      step();
    end

    // Locked burst by m1 while m0 waits.
    idle(1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'h40, 32'hA0, 1'b1);
    #2; check1("burst0_m1_gnt", m1_gnt, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 32'h44 + 32'(4 * k), 32'hA1 + 32'(k), k < 2);
      #2;
      check1("burst_m0_held", m0_gnt, 1'b0);
      check1("burst_m1_gnt", m1_gnt, 1'b1);
      step();
    end
    idle(1'b1);
    #2; check1("burst_after_m0_gnt", m0_gnt, 1'b1);
    step();

    // Watchdog: m1 locks and idles.
    idle(1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'h50, 32'hB0, 1'b1);
    #2; check1("wd_m1_lock_gnt", m1_gnt, 1'b1);
    step();
    idle(1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'h44, 32'd0, 1'b0);
    for (int k = 0; k <= LockMax; k++) begin
      #2; check1("wd_m0_blocked", m0_gnt, 1'b0);
      step();
    end
    #2; check1("wd_m0_released_gnt", m0_gnt, 1'b1);
    step();

    // Watchdog: m0 locks and idles; m1 must win the conflict after release.
    drive(1'b0, 1'b1, 1'b1, 32'h60, 32'hC0, 1'b1);
    #2;
    check1("wd2_m0_lock_gnt", m0_gnt, 1'b1);
    check32("wd_m0_rdata", m0_rdata, 32'hA1);
    step();
    idle(1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h44, 32'd0, 1'b0);
    for (int k = 0; k < LockMax; k++) begin
      #2; check1("wd2_m1_blocked", m1_gnt, 1'b0);
      step();
    end
    drive(1'b0, 1'b1, 1'b0, 32'h48, 32'd0, 1'b0);
    #2;
    check1("wd2_release_m0", m0_gnt, 1'b0);
    check1("wd2_release_m1", m1_gnt, 1'b0);
    step();
    #2;
    check1("wd2_conflict_m1", m1_gnt, 1'b1);
    check1("wd2_conflict_m0", m0_gnt, 1'b0);
    step();
    idle(1'b1);
    #2;
    check1("wd2_m0_after", m0_gnt, 1'b1);
    check1("wd2_m1_rvalid", m1_rvalid, 1'b1);
    check32("wd2_m1_rdata", m1_rdata, 32'hA1);
    step();

    // Reset in the cycle after a locked read by m1.
    idle(1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1);
    #2; check1("rst_m1_rd_gnt", m1_gnt, 1'b1);
    step();
    rst = 1'b1;
    idle(1'b1);
    #2;
    check1("rst_m1_rvalid", m1_rvalid, 1'b0);
    check32("rst_m1_rdata", m1_rdata, 32'd0);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h14, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h18, 32'd0, 1'b0);
    #2;
    check1("post_rst_m0_gnt", m0_gnt, 1'b1);
    check1("post_rst_m1_gnt", m1_gnt, 1'b0);
    step();
    idle(1'b0); idle(1'b1);
    #2;
    check32("post_rst_m0_rdata", m0_rdata, 32'hCAFE_F00D);
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
